vector_mem_arbiter: RTL
=======================

VECTOR_MEM_ARBITER -- requirements
Module: vector_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of vector load/store units sharing one memory port.
REQ-002 SHALL have parameter CORE_ID_BASE, default 8: core_id of requester 0; requester i owns core_id CORE_ID_BASE+i.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 16: maximum in-flight requests per requester.
REQ-004 SHALL have clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have req_in[NUM_REQ], input, request_t: per-unit memory request, held until granted.
REQ-007 SHALL have req_grant[NUM_REQ], output, 1 each: one-cycle acceptance pulse to the unit.
REQ-008 SHALL have mem_req, output, request_t: registered request to memory.
REQ-009 SHALL have mem_grant, input, 1: memory accepts mem_req this cycle.
REQ-010 SHALL have mem_rsp, input, request_t: memory response, tagged by core_id.
REQ-011 SHALL have rsp_out[NUM_REQ], output, request_t: routed per-unit response.
REQ-012 SHALL have rsp_drop, output, 1: pulse when a response core_id maps to no requester.

Function
REQ-013 Requester i SHALL be eligible when req_in[i].vld=1 and outstanding[i] < MAX_OUTSTANDING.
REQ-014 Capture SHALL occur when any requester is eligible and (mem_req.vld=0 or mem_grant=1).
REQ-015 Winner SHALL be the first eligible index searched from rr_ptr upward, wrapping NUM_REQ-1 to 0.
REQ-016 On capture, mem_req SHALL load req_in[winner] next edge, with core_id forced to CORE_ID_BASE+winner.
REQ-017 req_grant[winner] SHALL be combinational and high in the capture cycle only; all other grants low.
REQ-018 rr_ptr SHALL become (winner+1) mod NUM_REQ on capture and hold otherwise.
REQ-019 mem_req SHALL hold stable while mem_req.vld=1 and mem_grant=0.
REQ-020 On mem_grant with no capture, mem_req SHALL clear to 0 next edge; grant-plus-capture SHALL give back-to-back issue, no bubble.
REQ-021 State SHALL be IDLE (mem_req.vld=0) or ISSUE (mem_req.vld=1): IDLE->ISSUE on capture; ISSUE->IDLE on mem_grant without capture; otherwise ISSUE holds.
REQ-022 outstanding[i] (REQUEST_COUNTER_WIDTH bits) SHALL increment on req_grant[i] and decrement on a routed response to i; both in one cycle SHALL leave it unchanged.
REQ-023 A response routed to a requester whose outstanding is 0 SHALL still be forwarded, and its counter SHALL not underflow.
REQ-024 mem_rsp.vld with core_id in [CORE_ID_BASE, CORE_ID_BASE+NUM_REQ-1] SHALL drive rsp_out[core_id-CORE_ID_BASE]=mem_rsp one cycle later; all other rsp_out SHALL be 0.
REQ-025 An out-of-range core_id SHALL drop the response and pulse rsp_drop for one cycle, one cycle later.
REQ-026 Request and response paths SHALL be independent and may be active in the same cycle.

Reset
REQ-027 Reset low SHALL asynchronously set mem_req=0, rsp_out=0, rsp_drop=0, rr_ptr=0, all outstanding=0, state IDLE.
REQ-028 Reset mid-ISSUE SHALL discard the held request with no grant or response replay; req_grant SHALL be 0 while reset is low.

Structure
REQ-029 request_t, READ_REQ/WRITE_REQ and REQUEST_COUNTER_WIDTH SHALL come from the shared package; NUM_MEM_REQUESTERS (=4) SHALL be added there.
REQ-030 Round-robin select SHALL be a sub-module rr_arbiter (inputs: eligible vector and rr_ptr; outputs: winner index and any_eligible).

Verification
REQ-031 Requesters 0 and 2 vld, mem_grant always 1 -> grants alternate 0,2,0,2, one per cycle, no idle cycles on mem_req.
REQ-032 Requester 1 vld, mem_grant=0 for 5 cycles -> mem_req stable with core_id=9, exactly one req_grant[1] pulse, no second capture until mem_grant.
REQ-033 Requester 3 issues 16 requests with no responses -> 17th not granted; one response core_id=11 -> granted within 2 cycles.
REQ-034 mem_rsp core_id=10 plus a grant to requester 2 in the same cycle -> rsp_out[2] valid next cycle, outstanding[2] unchanged.
REQ-035 mem_rsp core_id=3 -> rsp_drop=1 for one cycle, all rsp_out=0.
REQ-036 Reset asserted in ISSUE with 2 requests outstanding -> mem_req=0 immediately, all counters 0, rr_ptr=0 after release.

Source files
------------

// File: rtl/vector_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vector_mem_arbiter_pkg
// Shared types and constants for the vector memory arbiter slice.
//   request_t             : packed memory request/response beat
//   req_type_e            : READ_REQ / WRITE_REQ command encoding
//   REQUEST_COUNTER_WIDTH : width of the per-requester outstanding counters
//   NUM_MEM_REQUESTERS    : default number of units sharing the memory port
// -----------------------------------------------------------------------------
package vector_mem_arbiter_pkg;

    localparam int NUM_MEM_REQUESTERS    = 4;
    // Must be wide enough to hold MAX_OUTSTANDING itself (16 -> 5 bits).
    localparam int REQUEST_COUNTER_WIDTH = 5;
    localparam int CORE_ID_WIDTH         = 8;
    localparam int ADDR_WIDTH            = 16;
    localparam int DATA_WIDTH            = 32;

    typedef logic [CORE_ID_WIDTH-1:0] core_id_t;

    typedef enum logic {
        READ_REQ  = 1'b0,
        WRITE_REQ = 1'b1
    } req_type_e;

    typedef struct packed {
        logic                  vld;
        req_type_e             cmd;
        core_id_t              core_id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } request_t;

    // True when core_id belongs to one of the count requesters starting at base.
    function automatic logic core_id_in_range(core_id_t id, int base, int count);
        return (int'(id) >= base) && (int'(id) < base + count);
    endfunction

endpackage

// File: rtl/vector_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// vector_mem_arbiter_if
// Bundles the requester, memory and response signals of the arbiter.
//   req_in[NUM_REQ]   : per-unit requests (held by the unit until granted)
//   req_grant         : one-cycle acceptance pulse per unit
//   mem_req           : registered request toward memory
//   mem_grant         : memory accepts mem_req this cycle
//   mem_rsp           : memory response tagged by core_id
//   rsp_out[NUM_REQ]  : routed per-unit responses
//   rsp_drop          : pulse for a response whose core_id matches no unit
// Modports: master = arbiter side, slave = units/memory/environment side.
// -----------------------------------------------------------------------------
interface vector_mem_arbiter_if
    import vector_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_MEM_REQUESTERS
) ();

    request_t             req_in  [NUM_REQ];
    logic [NUM_REQ-1:0]   req_grant;
    request_t             mem_req;
    logic                 mem_grant;
    request_t             mem_rsp;
    request_t             rsp_out [NUM_REQ];
    logic                 rsp_drop;

    modport master (
        input  req_in,
        input  mem_grant,
        input  mem_rsp,
        output req_grant,
        output mem_req,
        output rsp_out,
        output rsp_drop
    );

    modport slave (
        output req_in,
        output mem_grant,
        output mem_rsp,
        input  req_grant,
        input  mem_req,
        input  rsp_out,
        input  rsp_drop
    );

endinterface

// File: rtl/vector_mem_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of eligible found
// by searching upward from rr_ptr and wrapping from N-1 back to 0.
//   eligible     : one bit per requester
//   rr_ptr       : index with highest priority this cycle
//   winner       : selected index (0 when nothing is eligible)
//   any_eligible : at least one eligible bit is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_eligible
);

    // Walk the offsets from farthest to nearest so the nearest eligible
    // index (lowest offset from rr_ptr) is the last one written and wins.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (eligible[IDX_W'((int'(rr_ptr) + off) % N)]) begin
                winner       = IDX_W'((int'(rr_ptr) + off) % N);
                any_eligible = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vector_mem_arbiter
// Shares one memory request port between NUM_REQ vector load/store units with
// round-robin arbitration, per-unit outstanding-request limits, and routes
// memory responses back to the owning unit by core_id.
//   clk   : single clock, all logic on the rising edge
//   reset : asynchronous, active-low
//   bus   : vector_mem_arbiter_if.master (requests, grants, memory port,
//           responses, drop pulse)
// Requester i is stamped with core_id CORE_ID_BASE+i on its way to memory.
// -----------------------------------------------------------------------------
module vector_mem_arbiter
    import vector_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = NUM_MEM_REQUESTERS,
    parameter int CORE_ID_BASE    = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    vector_mem_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = REQUEST_COUNTER_WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // mem_req ownership: IDLE means the output register is empty.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]         state_reg, state_next;
    request_t           mem_req_reg, mem_req_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]      outstanding_reg [NUM_REQ];
    request_t           rsp_out_reg     [NUM_REQ];
    logic               rsp_drop_reg;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_hit;
    logic [IDX_W-1:0]   winner;
    logic               any_eligible;
    logic               capture;
    logic               rsp_in_range;
    logic [IDX_W-1:0]   rsp_idx;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign eligible[gi] = bus.req_in[gi].vld && (outstanding_reg[gi] < MAX_CNT);
            assign grant[gi]    = capture && (winner == IDX_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .eligible     (eligible),
        .rr_ptr       (rr_ptr_reg),
        .winner       (winner),
        .any_eligible (any_eligible)
    );

    // A new request may enter when the output register is empty or is being
    // drained this very cycle, which gives back-to-back issue. Gating with
    // reset keeps the grant pulse quiet while reset is held low.
    assign capture       = reset && any_eligible && ((state_reg == IDLE) || bus.mem_grant);
    assign bus.req_grant = grant;

    always_comb begin
        state_next   = state_reg;
        mem_req_next = mem_req_reg;
        rr_ptr_next  = rr_ptr_reg;
        if (capture) begin
            mem_req_next         = bus.req_in[winner];
            mem_req_next.core_id = core_id_t'(CORE_ID_BASE + int'(winner));
            state_next           = ISSUE;
            rr_ptr_next          = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else if ((state_reg == ISSUE) && bus.mem_grant) begin
            mem_req_next = '0;
            state_next   = IDLE;
        end
    end

    assign bus.mem_req = mem_req_reg;

    // ------------------------------------------------------------------
    // Response path (independent of the request path)
    // ------------------------------------------------------------------
    always_comb begin
        rsp_in_range = core_id_in_range(bus.mem_rsp.core_id, CORE_ID_BASE, NUM_REQ);
        rsp_idx      = '0;
        if (rsp_in_range) begin
            rsp_idx = IDX_W'(int'(bus.mem_rsp.core_id) - CORE_ID_BASE);
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_hit[gi]     = bus.mem_rsp.vld && rsp_in_range && (rsp_idx == IDX_W'(gi));
            assign bus.rsp_out[gi] = rsp_out_reg[gi];
        end
    endgenerate

    assign bus.rsp_drop = rsp_drop_reg;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            mem_req_reg  <= '0;
            rr_ptr_reg   <= '0;
            rsp_drop_reg <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_out_reg[i]     <= '0;
                outstanding_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            mem_req_reg  <= mem_req_next;
            rr_ptr_reg   <= rr_ptr_next;
            rsp_drop_reg <= bus.mem_rsp.vld && !rsp_in_range;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_out_reg[i] <= rsp_hit[i] ? bus.mem_rsp : '0;
                // Grant and response together cancel out; a response to a
                // unit with nothing outstanding is still forwarded above but
                // must not wrap the counter.
                if (grant[i] && !rsp_hit[i]) begin
                    outstanding_reg[i] <= outstanding_reg[i] + 1'b1;
                end else if (!grant[i] && rsp_hit[i] && (outstanding_reg[i] != '0)) begin
                    outstanding_reg[i] <= outstanding_reg[i] - 1'b1;
                end
            end
        end
    end

endmodule
